// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad: scanner state encoding, matrix
// dimensions and the row/column to hex key map (also used by the display path).
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic {
        SCAN = 1'b0,
        HOLD = 1'b1
    } scan_state_e;

    // Physical layout of the keypad, indexed [row][col]
    localparam logic [3:0] KEY_MAP [NUM_ROWS][NUM_COLS] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Index of the lowest-numbered active-low row; 0 when none is low
    function automatic logic [1:0] lowest_low_row(input logic [NUM_ROWS-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Pin-level and result signals of the keypad scanner. The scanner is the
// master (drives columns and results); the keypad/consumer side is the slave.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [NUM_ROWS-1:0] rows;
    logic [NUM_COLS-1:0] cols;
    logic [3:0]          key_code;
    logic                key_pressed;

    modport master (
        input  rows,
        output cols,
        output key_code,
        output key_pressed
    );

    modport slave (
        output rows,
        input  cols,
        input  key_code,
        input  key_pressed
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs. Reset value is a parameter so
// active-low inputs such as keypad rows can reset to their idle (all-ones) level.
module sync_2ff #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two register stages to settle metastability before the value is used
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scan controller for the 4x4 matrix keypad. Drives one column low at a
// time, samples the synchronised rows at the end of each column dwell and
// latches the first key found. Bounce filtering is left to the downstream
// debouncer. SCAN_DIV must be at least 4.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 4800
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scanner_if.master  kif
);

    localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [NUM_ROWS-1:0] rows_s;

    scan_state_e         state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [1:0]          col_q, col_d;
    logic [1:0]          row_q, row_d;
    logic [3:0]          code_q, code_d;
    logic                pressed_q, pressed_d;

    logic                terminal;
    logic                any_low;
    logic                released;
    logic [1:0]          low_row;

    sync_2ff #(
        .WIDTH     (NUM_ROWS),
        .RESET_VAL ({NUM_ROWS{1'b1}})
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (kif.rows),
        .q     (rows_s)
    );

    assign terminal = (div_q == DIV_LAST);
    assign any_low  = ~&rows_s;
    assign released = rows_s[row_q];
    assign low_row  = lowest_low_row(rows_s);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SCAN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter HOLD when the dwell ends with a row low, leave it when the latched row returns high
    always_comb begin
        state_d = state_q;
        case (state_q)
            SCAN: begin
                if (terminal && any_low) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (released) begin
                    state_d = SCAN;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    // Next values of divider, column, latched row and the registered outputs
    always_comb begin
        div_d     = div_q;
        col_d     = col_q;
        row_d     = row_q;
        code_d    = code_q;
        pressed_d = pressed_q;
        case (state_q)
            SCAN: begin
                if (terminal) begin
                    div_d = '0;
                    if (any_low) begin
                        row_d     = low_row;
                        code_d    = KEY_MAP[low_row][col_q];
                        pressed_d = 1'b1;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            HOLD: begin
                div_d = '0;
                if (released) begin
                    pressed_d = 1'b0;
                    col_d     = col_q + 2'd1;
                end
            end
            default: begin
                div_d = '0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q     <= '0;
            col_q     <= 2'd0;
            row_q     <= 2'd0;
            code_q    <= 4'h0;
            pressed_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            col_q     <= col_d;
            row_q     <= row_d;
            code_q    <= code_d;
            pressed_q <= pressed_d;
        end
    end

    assign kif.cols        = ~(4'b0001 << col_q);
    assign kif.key_code    = code_q;
    assign kif.key_pressed = pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a fast scan divider. A keypad
// model turns held keys into row levels; expected output events are queued by
// the stimulus and checked by an independent monitor.
module tb_keypad_scanner;

    localparam int SCAN_DIV    = 8;
    localparam int PRESS_BOUND = 4 * SCAN_DIV + 3;
    localparam int REL_BOUND   = 3;

    typedef struct {
        logic       kp;
        logic [3:0] code;
        logic [3:0] cols;
    } exp_t;

    logic clk;
    logic reset;
    logic [3:0][3:0] held;
    logic mon_en;

    int n_vec;
    int n_miss;

    exp_t exp_q[$];
    exp_t mon_e;
    logic       prev_kp;
    logic [3:0] prev_code;

    // Key legend in reading order, row by row
    logic [3:0] key_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC,
                                 4'hE, 4'h0, 4'hF, 4'hD};

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kif   (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a row reads low when a held key sits on the driven column
    always_comb begin
        logic [3:0] rows_v;
        rows_v = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (held[r][c] && kif.cols[c] == 1'b0) begin
                    rows_v[r] = 1'b0;
                end
            end
        end
        kif.rows = rows_v;
    end

    function automatic logic [3:0] col_drive(input int c);
        logic [3:0] v;
        v = 4'b1111;
        v[c % 4] = 1'b0;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int r, input int c, input logic on);
        held[r][c] = on;
    endtask

    task automatic pushExp(input logic kp, input logic [3:0] code, input logic [3:0] cols);
        exp_t e;
        e.kp   = kp;
        e.code = code;
        e.cols = cols;
        exp_q.push_back(e);
    endtask

    task automatic waitKp(input logic value, input int bound, input string name);
        int n;
        n = 0;
        while (kif.key_pressed !== value && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {7'd0, kif.key_pressed}, {7'd0, value});
    endtask

    task automatic pressAndRelease(input int r, input int c, input int extra);
        logic [3:0] code;
        code = key_tab[r * 4 + c];
        pushExp(1'b1, code, col_drive(c));
        applyStimulus(r, c, 1'b1);
        waitKp(1'b1, PRESS_BOUND, "press_latency");
        repeat (extra) @(negedge clk);
        pushExp(1'b0, code, col_drive(c + 1));
        applyStimulus(r, c, 1'b0);
        waitKp(1'b0, REL_BOUND, "release_latency");
    endtask

    // Monitor: every change of the reported key state must match the next queued expectation
    always @(negedge clk) begin
        if (mon_en) begin
            if (kif.key_pressed !== prev_kp || kif.key_code !== prev_code) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("[TB] FAIL unexpected_event: got kp=%0b code=%0h cols=%b expected no change at %0t",
                             kif.key_pressed, kif.key_code, kif.cols, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("event_kp",   {7'd0, kif.key_pressed}, {7'd0, mon_e.kp});
                    checkOutput("event_code", {4'd0, kif.key_code},    {4'd0, mon_e.code});
                    checkOutput("event_cols", {4'd0, kif.cols},        {4'd0, mon_e.cols});
                end
                prev_kp   = kif.key_pressed;
                prev_code = kif.key_code;
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [3:0] last_cols;
        int n;
        n_vec     = 0;
        n_miss    = 0;
        mon_en    = 1'b0;
        held      = '0;
        prev_kp   = 1'b0;
        prev_code = 4'h0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state and free-running column rotation with no key
        checkOutput("reset_cols", {4'd0, kif.cols}, 8'h0E);
        checkOutput("reset_kp",   {7'd0, kif.key_pressed}, 8'h00);
        checkOutput("reset_code", {4'd0, kif.key_code}, 8'h00);
        reset  = 1'b0;
        mon_en = 1'b1;
        for (int k = 1; k < 80; k++) begin
            @(negedge clk);
            checkOutput("idle_cols", {4'd0, kif.cols}, {4'd0, col_drive((k / SCAN_DIV) % 4)});
        end
        checkOutput("idle_kp",   {7'd0, kif.key_pressed}, 8'h00);
        checkOutput("idle_code", {4'd0, kif.key_code}, 8'h00);

        // Single key r1c2 ('6'), release moves scan to column 3
        pressAndRelease(1, 2, 10);
        @(negedge clk);
        checkOutput("after_release_code", {4'd0, kif.key_code}, 8'h06);

        // Two keys in one column: lowest row wins; extra key in HOLD is ignored
        pushExp(1'b1, 4'hA, col_drive(3));
        applyStimulus(0, 3, 1'b1);
        applyStimulus(2, 3, 1'b1);
        waitKp(1'b1, PRESS_BOUND, "multi_press");
        applyStimulus(3, 0, 1'b1);
        repeat (40) @(negedge clk);
        checkOutput("hold_code", {4'd0, kif.key_code}, 8'h0A);
        checkOutput("hold_cols", {4'd0, kif.cols}, {4'd0, col_drive(3)});
        checkOutput("hold_kp",   {7'd0, kif.key_pressed}, 8'h01);
        pushExp(1'b0, 4'hA, col_drive(0));
        applyStimulus(0, 3, 1'b0);
        applyStimulus(2, 3, 1'b0);
        applyStimulus(3, 0, 1'b0);
        waitKp(1'b0, REL_BOUND, "multi_release");
        repeat (5) @(negedge clk);

        // Reset during HOLD with the key still held, then re-detection
        pushExp(1'b1, 4'hF, col_drive(2));
        applyStimulus(3, 2, 1'b1);
        waitKp(1'b1, PRESS_BOUND, "f_press");
        repeat (4) @(negedge clk);
        pushExp(1'b0, 4'h0, col_drive(0));
        pushExp(1'b1, 4'hF, col_drive(2));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midhold_reset_cols", {4'd0, kif.cols}, 8'h0E);
        waitKp(1'b1, PRESS_BOUND, "f_redetect");
        pushExp(1'b0, 4'hF, col_drive(3));
        applyStimulus(3, 2, 1'b0);
        waitKp(1'b0, REL_BOUND, "f_release");

        // One-cycle row pulse in the middle of a column dwell is never reported
        last_cols = kif.cols;
        n = 0;
        while (!(kif.cols == 4'b1110 && last_cols != 4'b1110) && n < 40) begin
            last_cols = kif.cols;
            @(negedge clk);
            n++;
        end
        checkOutput("align_col0", {4'd0, kif.cols}, 8'h0E);
        repeat (2) @(negedge clk);
        applyStimulus(0, 0, 1'b1);
        @(negedge clk);
        applyStimulus(0, 0, 1'b0);
        repeat (40) @(negedge clk);
        checkOutput("glitch_kp", {7'd0, kif.key_pressed}, 8'h00);

        // Random single-key presses against the key legend
        for (int t = 0; t < 12; t++) begin
            int r;
            int c;
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            pressAndRelease(r, c, int'($urandom_range(0, 20)));
            repeat ($urandom_range(1, 20)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        checkOutput("queue_empty", 8'(exp_q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
